// File: rtl/hidden_delta.sv
// Hidden-layer delta stage: accumulates sum(w*d) over a stream of next-layer
// weight/delta pairs in signed Q8.24, then scales the sum by the latched dadz term.
module hidden_delta #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24,
    parameter int NWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NWIDTH-1:0] len,
    input  logic [DWIDTH-1:0] dadz_in,
    input  logic [DWIDTH-1:0] w_in,
    input  logic [DWIDTH-1:0] d_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] delta_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshakes: a term is consumed on a rising edge where in_valid && in_ready;
    // the result is consumed on a rising edge where out_valid && out_ready.
    // Neither valid may depend on the matching ready; both readies/valids come
    // straight from the state register.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        SCALE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int PW = 2 * DWIDTH;
    localparam logic signed [PW-1:0] SAT_MAX = {{(DWIDTH + 1){1'b0}}, {(DWIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(DWIDTH + 1){1'b1}}, {(DWIDTH - 1){1'b0}}};
    localparam logic [DWIDTH-1:0] OUT_MAX = {1'b0, {(DWIDTH - 1){1'b1}}};
    localparam logic [DWIDTH-1:0] OUT_MIN = {1'b1, {(DWIDTH - 1){1'b0}}};

    // Full-width product, floor shift (arithmetic), then clamp to DWIDTH.
    function automatic logic [DWIDTH-1:0] mul(input logic [DWIDTH-1:0] a,
                                              input logic [DWIDTH-1:0] b);
        logic signed [PW-1:0] wa;
        logic signed [PW-1:0] wb;
        logic signed [PW-1:0] p;
        wa = {{DWIDTH{a[DWIDTH-1]}}, a};
        wb = {{DWIDTH{b[DWIDTH-1]}}, b};
        p  = (wa * wb) >>> FRAC;
        if (p > SAT_MAX) begin
            mul = OUT_MAX;
        end else if (p < SAT_MIN) begin
            mul = OUT_MIN;
        end else begin
            mul = p[DWIDTH-1:0];
        end
    endfunction

    function automatic logic [DWIDTH-1:0] add(input logic [DWIDTH-1:0] a,
                                              input logic [DWIDTH-1:0] b);
        logic [DWIDTH:0] s;
        s = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
        if (s[DWIDTH] != s[DWIDTH-1]) begin
            add = s[DWIDTH] ? OUT_MIN : OUT_MAX;
        end else begin
            add = s[DWIDTH-1:0];
        end
    endfunction

    state_t              state_q, state_d;
    logic [DWIDTH-1:0]   acc_q, acc_d;
    logic [DWIDTH-1:0]   dz_q, dz_d;
    logic [DWIDTH-1:0]   delta_q, delta_d;
    logic [NWIDTH-1:0]   len_q, len_d;
    logic [NWIDTH-1:0]   count_q, count_d;
    logic                beat;
    logic                last_beat;

    assign beat      = (state_q == ACC) && in_valid;
    assign last_beat = (count_q == NWIDTH'(len_q - 1'b1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dz_d    = dz_q;
        delta_d = delta_q;
        len_d   = len_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    dz_d    = dadz_in;
                    len_d   = len;
                    state_d = (len != '0) ? ACC : SCALE;
                end
            end
            ACC: begin
                if (beat) begin
                    acc_d   = add(acc_q, mul(w_in, d_in));
                    count_d = NWIDTH'(count_q + 1'b1);
                    if (last_beat) begin
                        state_d = SCALE;
                    end
                end
            end
            SCALE: begin
                delta_d = mul(acc_q, dz_q);
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dz_q    <= '0;
            delta_q <= '0;
            len_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dz_q    <= dz_d;
            delta_q <= delta_d;
            len_q   <= len_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign delta_out = delta_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hidden_delta.sv
// Directed bench for hidden_delta: a vector table of whole transactions plus
// hand-written sequences for flow control, output stall and mid-transaction reset.
module tb_hidden_delta;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  len;
    logic [31:0] dadz_in;
    logic [31:0] w_in;
    logic [31:0] d_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] delta_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hidden_delta dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .dadz_in   (dadz_in),
        .w_in      (w_in),
        .d_in      (d_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .delta_out (delta_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    typedef struct {
        string            name;
        logic [4:0]       len;
        logic [31:0]      dadz;
        logic [2:0][31:0] w;
        logic [2:0][31:0] d;
        logic [31:0]      exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic start_txn(input logic [4:0] l, input logic [31:0] dz);
        start   = 1'b1;
        len     = l;
        dadz_in = dz;
        @(negedge clk);
        start   = 1'b0;
        len     = 5'($urandom_range(0, 31));
        dadz_in = $urandom;
    endtask

    task automatic send_beat(input string name, input logic [31:0] w, input logic [31:0] d);
        logic ok;
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        w_in     = w;
        d_in     = d;
        for (int t = 0; t < 20 && !done; t++) begin
            ok = in_ready;
            @(negedge clk);
            if (ok) done = 1'b1;
        end
        in_valid = 1'b0;
        w_in     = $urandom;
        d_in     = $urandom;
        check({name, " beat accepted"}, {31'd0, done}, 32'd1);
    endtask

    // Counts falling edges until out_valid; also flags any in_ready seen meanwhile.
    task automatic wait_valid(output int k, output logic saw_ready);
        k = 0;
        saw_ready = 1'b0;
        for (int t = 1; t <= 20 && k == 0; t++) begin
            @(negedge clk);
            if (in_ready) saw_ready = 1'b1;
            if (out_valid) k = t;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int   k;
        logic saw_ready;
        logic [31:0] held;

        vecs[0] = '{"basic", 5'd2, 32'hFFC00000,
                    {32'h0, 32'h00800000, 32'h01000000},
                    {32'h0, 32'h02000000, 32'h02000000}, 32'hFF400000};
        vecs[1] = '{"empty", 5'd0, 32'h01000000,
                    {32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0}, 32'h00000000};
        vecs[2] = '{"sat_pos", 5'd1, 32'h01000000,
                    {32'h0, 32'h0, 32'h7F000000},
                    {32'h0, 32'h0, 32'h02000000}, 32'h7FFFFFFF};
        vecs[3] = '{"sat_neg", 5'd1, 32'h01000000,
                    {32'h0, 32'h0, 32'h81000000},
                    {32'h0, 32'h0, 32'h02000000}, 32'h80000000};
        vecs[4] = '{"floor", 5'd1, 32'h01000000,
                    {32'h0, 32'h0, 32'hFFFFFFFF},
                    {32'h0, 32'h0, 32'h00800000}, 32'hFFFFFFFF};

        rst_n = 1'b0; start = 1'b0; len = '0; dadz_in = '0;
        w_in = '0; d_in = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset delta_out", delta_out, 32'h0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);

        // Table: each transaction with out_ready held high.
        for (int v = 0; v < 5; v++) begin
            start_txn(vecs[v].len, vecs[v].dadz);
            check({vecs[v].name, " busy"}, {31'd0, busy}, 32'd1);
            for (int b = 0; b < int'(vecs[v].len); b++)
                send_beat(vecs[v].name, vecs[v].w[b], vecs[v].d[b]);
            // One edge already elapsed since the accept (or start); the second raises out_valid.
            wait_valid(k, saw_ready);
            check({vecs[v].name, " latency edges"}, 32'(k + 1), 32'd2);
            check({vecs[v].name, " delta_out"}, delta_out, vecs[v].exp);
            if (vecs[v].len == 5'd0)
                check({vecs[v].name, " in_ready seen"}, {31'd0, saw_ready}, 32'd0);
            @(negedge clk);
            check({vecs[v].name, " out_valid one cycle"}, {31'd0, out_valid}, 32'd0);
            check({vecs[v].name, " idle busy"}, {31'd0, busy}, 32'd0);
            check({vecs[v].name, " delta held in idle"}, delta_out, vecs[v].exp);
        end

        // Gaps between beats and dadz_in changing after start: 2.25 * 2.0 = 4.5.
        start_txn(5'd3, 32'h02000000);
        send_beat("flow", 32'h01000000, 32'h01000000);
        dadz_in = 32'h7F000000;
        repeat (2) @(negedge clk);
        check("flow in_ready in gap", {31'd0, in_ready}, 32'd1);
        check("flow state in gap", {30'd0, dbg_state}, 32'd1);
        send_beat("flow", 32'h02000000, 32'h00800000);
        dadz_in = 32'h80000000;
        repeat (2) @(negedge clk);
        send_beat("flow", 32'h00800000, 32'h00800000);
        check("flow in_ready after last", {31'd0, in_ready}, 32'd0);
        wait_valid(k, saw_ready);
        check("flow latency edges", 32'(k + 1), 32'd2);
        check("flow delta_out", delta_out, 32'h04800000);
        @(negedge clk);

        // Output stall for 5 cycles with a stray start in HOLD: 1.0 * 0.5.
        out_ready = 1'b0;
        start_txn(5'd1, 32'h00800000);
        send_beat("stall", 32'h01000000, 32'h01000000);
        wait_valid(k, saw_ready);
        check("stall reached hold", {31'd0, out_valid}, 32'd1);
        held = delta_out;
        check("stall delta_out", held, 32'h00800000);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                start = 1'b1; len = 5'd0; dadz_in = 32'h0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check("stall out_valid held", {31'd0, out_valid}, 32'd1);
            check("stall delta stable", delta_out, 32'h00800000);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall released out_valid", {31'd0, out_valid}, 32'd0);
        check("stall released state", {30'd0, dbg_state}, 32'd0);
        repeat (2) @(negedge clk);
        check("stray start ignored busy", {31'd0, busy}, 32'd0);
        check("stray start ignored delta", delta_out, 32'h00800000);

        // Reset after one of three beats, then a fresh basic transaction.
        start_txn(5'd3, 32'hFFC00000);
        send_beat("rst", 32'h01000000, 32'h02000000);
        check("rst pre busy", {31'd0, busy}, 32'd1);
        do_reset();
        check("rst delta_out", delta_out, 32'h0);
        check("rst in_ready", {31'd0, in_ready}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst state", {30'd0, dbg_state}, 32'd0);
        start_txn(5'd2, 32'hFFC00000);
        send_beat("rst basic", 32'h01000000, 32'h02000000);
        send_beat("rst basic", 32'h00800000, 32'h02000000);
        wait_valid(k, saw_ready);
        check("rst basic latency edges", 32'(k + 1), 32'd2);
        check("rst basic delta_out", delta_out, 32'hFF400000);
        @(negedge clk);

        // Back-to-back: start in the cycle right after the HOLD handshake.
        start_txn(5'd1, 32'h01000000);
        send_beat("b2b first", 32'h00800000, 32'h00800000);
        wait_valid(k, saw_ready);
        check("b2b first delta", delta_out, 32'h00400000);
        @(negedge clk);
        start_txn(5'd0, 32'h01000000);
        wait_valid(k, saw_ready);
        check("b2b second latency edges", 32'(k + 1), 32'd2);
        check("b2b second delta", delta_out, 32'h0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hidden_delta.md
Name: hidden_delta

Overview:
- Backpropagation stage directly downstream of the sigmoid-derivative block.
- Streams next-layer weight/delta pairs and accumulates sum(w*d) in Q8.24.
- Scales the sum by the derivative value (dadz output) to produce one hidden-neuron delta, then presents it on a valid/ready output.
- One instance per hidden neuron, or time-shared by the training controller.

Parameters:
- DWIDTH, 32, data width; signed Q8.24 fixed point.
- FRAC, 24, fractional bits; 1.0 = 32'h01000000.
- NWIDTH, 5, width of term-count input (max 2^NWIDTH-1 terms per delta).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  pulse; begins a transaction (sampled only in IDLE)
- len  in  NWIDTH  number of (w,d) terms, sampled with start
- dadz_in  in  DWIDTH  derivative term from dadz stage, sampled with start
- w_in  in  DWIDTH  next-layer weight, signed Q8.24
- d_in  in  DWIDTH  next-layer delta, signed Q8.24
- in_valid  in  1  w_in/d_in valid
- in_ready  out  1  block accepts a term this cycle
- delta_out  out  DWIDTH  resulting hidden delta, signed Q8.24
- out_valid  out  1  delta_out valid
- out_ready  in  1  consumer accepts delta_out
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0 at an edge, any state, including mid-transaction):
  - State returns to IDLE.
  - acc, count, dz_reg, delta_out all 0.
  - in_ready=0, out_valid=0, busy=0.
  - A partial transaction is discarded.
- mul(a,b): 64-bit signed product, arithmetic shift right FRAC (floor toward -inf). Saturate to 32'h7FFFFFFF / 32'h80000000 if outside the signed 32-bit range.
- add(a,b): signed 32-bit sum, saturated the same way.
- FSM states: IDLE, ACC, SCALE, HOLD.
- IDLE:
  - in_ready=0.
  - start=1 and len!=0: latch len and dz_reg<=dadz_in; acc<=0, count<=0; go to ACC.
  - start=1 and len==0: acc<=0, dz_reg<=dadz_in; go to SCALE.
- ACC:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready: acc<=add(acc, mul(w_in,d_in)), count<=count+1.
  - When the accepted beat is number len (count==len-1): in_ready deasserts at the next edge and the state goes to SCALE.
  - Cycles with in_valid=0 hold all state.
- SCALE: single cycle; delta_out<=mul(acc,dz_reg); go to HOLD.
- HOLD:
  - out_valid=1; delta_out stable.
  - out_ready=1: out_valid clears at the edge and the state goes to IDLE.
- start outside IDLE is ignored. dadz_in changes after start have no effect.
- Latency: out_valid rises at the 2nd rising edge after the edge that accepted the last term. For len=0, it rises 2 edges after start.
- Back-to-back operation: start may be asserted in the cycle after the HOLD handshake, since the state is IDLE by then.
- delta_out holds its last value in IDLE; it changes only in SCALE or on reset.

Test Plan:
- Basic: len=2, dadz_in=32'hFFC00000 (-0.25), terms (32'h01000000, 32'h02000000), (32'h00800000, 32'h02000000), out_ready=1 -> delta_out=32'hFF400000 (-0.75). out_valid is high exactly 1 cycle, 2 edges after the last accept.
- Empty: start with len=0, dadz_in=32'h01000000 -> delta_out=0, out_valid high 2 edges after start, in_ready never asserts.
- Saturation: len=1, w=32'h7F000000, d=32'h02000000, dadz_in=32'h01000000 -> acc saturates, delta_out=32'h7FFFFFFF. Repeat with w=32'h81000000 -> 32'h80000000.
- Flow control:
  - len=3 with in_valid low for 2 cycles between beats, and dadz_in changed mid-transaction -> result uses the dadz value from start.
  - out_ready low for 5 cycles -> out_valid and delta_out stay stable.
  - A start pulse during HOLD is ignored.
- Floor rounding: len=1, w=32'hFFFFFFFF, d=32'h00800000, dadz_in=32'h01000000 -> delta_out=32'hFFFFFFFF.
- Reset mid-ACC: rst_n=0 for 1 cycle after 1 of 3 beats -> all outputs 0, state IDLE. A fresh Basic transaction then gives 32'hFF400000.
